fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bundles the ROM read port and the instruction hand-off toward the decoder.
// The master side is the fetch unit. The slave side is the ROM and decoder environment.
interface fetch_unit_if #(
    parameter int c_addr_width = 8,
    parameter int c_data_width = 8
);
    logic [c_addr_width-1:0] o_rom_address;
    logic                    o_rom_enable_out;
    logic [c_data_width-1:0] i_rom_data;
    logic [c_data_width-1:0] o_instr;
    logic                    o_instr_valid;
    logic                    i_instr_ready;

    modport master (
        output o_rom_address,
        output o_rom_enable_out,
        input  i_rom_data,
        output o_instr,
        output o_instr_valid,
        input  i_instr_ready
    );

    modport slave (
        input  o_rom_address,
        input  o_rom_enable_out,
        output i_rom_data,
        input  o_instr,
        input  o_instr_valid,
        output i_instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Three-state instruction fetcher: IDLE parks the unit, FETCH reads the ROM, and HOLD waits for the decoder.
// A jump overrides everything except reset. The wrap flag is sticky until the next reset.
module fetch_unit #(
    parameter int c_addr_width = 8,
    parameter int c_data_width = 8,
    parameter int c_reset_pc   = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_run,
    input  logic                    i_jump,
    input  logic [c_addr_width-1:0] i_jump_addr,
    fetch_unit_if.master            bus,
    output logic [c_addr_width-1:0] o_pc,
    output logic                    o_wrapped
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                  state;
    logic [c_addr_width-1:0] pc;
    logic [c_data_width-1:0] instr;
    logic                    instr_valid;
    logic                    rom_enable;
    logic                    wrapped;

    assign bus.o_rom_address    = pc;
    assign bus.o_rom_enable_out = rom_enable;
    assign bus.o_instr          = instr;
    assign bus.o_instr_valid    = instr_valid;
    assign o_pc                 = pc;
    assign o_wrapped            = wrapped;

    // The ROM enable is registered together with the next state, so it is high exactly while in FETCH.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            pc          <= c_addr_width'(c_reset_pc);
            instr       <= '0;
            instr_valid <= 1'b0;
            rom_enable  <= 1'b0;
            wrapped     <= 1'b0;
        end else if (i_jump) begin
            pc          <= i_jump_addr;
            instr_valid <= 1'b0;
            state       <= i_run ? FETCH : IDLE;
            rom_enable  <= i_run;
        end else begin
            case (state)
                IDLE: begin
                    if (i_run) begin
                        state      <= FETCH;
                        rom_enable <= 1'b1;
                    end
                end
                FETCH: begin
                    instr       <= bus.i_rom_data;
                    instr_valid <= 1'b1;
                    pc          <= pc + 1'b1;
                    if (pc == '1) begin
                        wrapped <= 1'b1;
                    end
                    state      <= HOLD;
                    rom_enable <= 1'b0;
                end
                HOLD: begin
                    if (instr_valid && bus.i_instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= i_run ? FETCH : IDLE;
                        rom_enable  <= i_run;
                    end
                end
                default: begin
                    state      <= IDLE;
                    rom_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a 256-entry behavioural ROM.
// Expected values are worked out by hand from the ROM contents below.
module tb_fetch_unit;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_run;
    logic       i_jump;
    logic [7:0] i_jump_addr;
    logic [7:0] o_pc;
    logic       o_wrapped;
    logic [7:0] rom [256];

    int compared   = 0;
    int mismatched = 0;

    fetch_unit_if #(.c_addr_width(8), .c_data_width(8)) bus ();

    fetch_unit #(.c_addr_width(8), .c_data_width(8), .c_reset_pc(0)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_run       (i_run),
        .i_jump      (i_jump),
        .i_jump_addr (i_jump_addr),
        .bus         (bus),
        .o_pc        (o_pc),
        .o_wrapped   (o_wrapped)
    );

    always #5 i_clk = ~i_clk;

    assign bus.i_rom_data = rom[bus.o_rom_address];

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    // Drive one cycle of inputs, then move to just past the next rising edge.
    task automatic applyStimulus(input logic rst_n, input logic run, input logic jump,
                                 input logic [7:0] jaddr, input logic ready);
        i_rst_n           = rst_n;
        i_run             = run;
        i_jump            = jump;
        i_jump_addr       = jaddr;
        bus.i_instr_ready = ready;
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
        rom[0]    = 8'h11;
        rom[1]    = 8'h22;
        rom[2]    = 8'h33;
        rom[8'h80] = 8'hA5;
        rom[8'hFF] = 8'hEE;
        rom[8'h10] = 8'hC3;

        // Reset state
        applyStimulus(0, 0, 0, 8'h00, 0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("rst_valid", 32'(bus.o_instr_valid), 0);
        checkOutput("rst_pc", 32'(o_pc), 0);
        checkOutput("rst_instr", 32'(bus.o_instr), 0);
        checkOutput("rst_wrapped", 32'(o_wrapped), 0);
        checkOutput("rst_en", 32'(bus.o_rom_enable_out), 0);

        // Streaming fetch of 0x11, 0x22, 0x33 with ready held high
        applyStimulus(1, 1, 0, 8'h00, 1);
        checkOutput("idle_to_fetch_en", 32'(bus.o_rom_enable_out), 1);
        checkOutput("idle_to_fetch_valid", 32'(bus.o_instr_valid), 0);
        applyStimulus(1, 1, 0, 8'h00, 1);
        checkOutput("f0_instr", 32'(bus.o_instr), 32'h11);
        checkOutput("f0_valid", 32'(bus.o_instr_valid), 1);
        checkOutput("f0_pc", 32'(o_pc), 1);
        checkOutput("f0_en", 32'(bus.o_rom_enable_out), 0);
        applyStimulus(1, 1, 0, 8'h00, 1);
        checkOutput("h0_valid", 32'(bus.o_instr_valid), 0);
        checkOutput("h0_en", 32'(bus.o_rom_enable_out), 1);
        applyStimulus(1, 1, 0, 8'h00, 1);
        checkOutput("f1_instr", 32'(bus.o_instr), 32'h22);
        checkOutput("f1_pc", 32'(o_pc), 2);
        applyStimulus(1, 1, 0, 8'h00, 1);
        applyStimulus(1, 1, 0, 8'h00, 1);
        checkOutput("f2_instr", 32'(bus.o_instr), 32'h33);
        checkOutput("f2_valid", 32'(bus.o_instr_valid), 1);
        checkOutput("f2_pc", 32'(o_pc), 3);
        checkOutput("addr_eq_pc", 32'(bus.o_rom_address), 3);

        // Jump back to 1 and stall the decoder on 0x22
        applyStimulus(1, 1, 1, 8'h01, 1);
        checkOutput("j1_valid", 32'(bus.o_instr_valid), 0);
        checkOutput("j1_pc", 32'(o_pc), 1);
        checkOutput("j1_en", 32'(bus.o_rom_enable_out), 1);
        applyStimulus(1, 1, 0, 8'h00, 0);
        checkOutput("stall_start_instr", 32'(bus.o_instr), 32'h22);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, i[0], 0, 8'h00, 0);
            checkOutput("stall_instr", 32'(bus.o_instr), 32'h22);
            checkOutput("stall_valid", 32'(bus.o_instr_valid), 1);
            checkOutput("stall_pc", 32'(o_pc), 2);
            checkOutput("stall_en", 32'(bus.o_rom_enable_out), 0);
        end
        applyStimulus(1, 1, 0, 8'h00, 1);
        checkOutput("release_valid", 32'(bus.o_instr_valid), 0);
        checkOutput("release_addr", 32'(bus.o_rom_address), 2);
        applyStimulus(1, 1, 0, 8'h00, 0);
        checkOutput("release_instr", 32'(bus.o_instr), 32'h33);
        checkOutput("release_pc", 32'(o_pc), 3);

        // Jump to 0x80 while holding a valid instruction
        applyStimulus(1, 1, 1, 8'h80, 0);
        checkOutput("j80_valid", 32'(bus.o_instr_valid), 0);
        checkOutput("j80_pc", 32'(o_pc), 32'h80);
        applyStimulus(1, 1, 0, 8'h00, 0);
        checkOutput("j80_instr", 32'(bus.o_instr), 32'hA5);
        checkOutput("j80_pc_after", 32'(o_pc), 32'h81);

        // Wrap past all-ones, then confirm a jump leaves the flag set
        applyStimulus(1, 1, 1, 8'hFF, 0);
        checkOutput("jff_wrapped", 32'(o_wrapped), 0);
        checkOutput("jff_pc", 32'(o_pc), 32'hFF);
        applyStimulus(1, 1, 0, 8'h00, 0);
        checkOutput("wrap_instr", 32'(bus.o_instr), 32'hEE);
        checkOutput("wrap_pc", 32'(o_pc), 0);
        checkOutput("wrap_flag", 32'(o_wrapped), 1);
        applyStimulus(1, 1, 1, 8'h10, 0);
        checkOutput("j10_pc", 32'(o_pc), 32'h10);
        checkOutput("j10_wrapped", 32'(o_wrapped), 1);
        applyStimulus(1, 1, 0, 8'h00, 0);
        checkOutput("j10_instr", 32'(bus.o_instr), 32'hC3);
        checkOutput("j10_pc_after", 32'(o_pc), 32'h11);
        checkOutput("j10_wrapped_after", 32'(o_wrapped), 1);

        // Reset asserted mid-cycle must not act before the clock edge
        i_rst_n = 1'b0;
        #2;
        checkOutput("async_valid", 32'(bus.o_instr_valid), 1);
        checkOutput("async_pc", 32'(o_pc), 32'h11);
        applyStimulus(0, 1, 1, 8'h40, 1);
        checkOutput("hrst_valid", 32'(bus.o_instr_valid), 0);
        checkOutput("hrst_pc", 32'(o_pc), 0);
        checkOutput("hrst_wrapped", 32'(o_wrapped), 0);
        checkOutput("hrst_instr", 32'(bus.o_instr), 0);
        checkOutput("hrst_en", 32'(bus.o_rom_enable_out), 0);

        // run dropping during FETCH: the fetch completes, then the unit parks after the handshake
        applyStimulus(1, 1, 0, 8'h00, 0);
        checkOutput("park_fetch_en", 32'(bus.o_rom_enable_out), 1);
        applyStimulus(1, 0, 0, 8'h00, 0);
        checkOutput("park_instr", 32'(bus.o_instr), 32'h11);
        checkOutput("park_valid", 32'(bus.o_instr_valid), 1);
        checkOutput("park_pc", 32'(o_pc), 1);
        applyStimulus(1, 0, 0, 8'h00, 1);
        checkOutput("park_hs_valid", 32'(bus.o_instr_valid), 0);
        checkOutput("park_hs_en", 32'(bus.o_rom_enable_out), 0);
        applyStimulus(1, 0, 0, 8'h00, 1);
        checkOutput("idle_ready_ignored_pc", 32'(o_pc), 1);
        checkOutput("idle_ready_ignored_en", 32'(bus.o_rom_enable_out), 0);
        checkOutput("idle_ready_ignored_instr", 32'(bus.o_instr), 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
